// File: rtl/seq_core_pkg.sv
// Shared opcode encodings, sequencer state type and instruction field layout
// for the seq_core instruction sequencer.
package seq_core_pkg;

   localparam logic [1:0] OP_PUSH = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_MULT = 2'b10;
   localparam logic [1:0] OP_SEND = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_SEND = 2'd2
   } state_e;

   // Instruction layout: {op, ra, rb, rc}; imm overlays the {rb, rc} fields.
   function automatic int unsigned op_lsb(input int unsigned rnw);
      return 3 * rnw;
   endfunction

   function automatic int unsigned ra_lsb(input int unsigned rnw);
      return 2 * rnw;
   endfunction

   function automatic int unsigned rb_lsb(input int unsigned rnw);
      return rnw;
   endfunction

   function automatic int unsigned rc_lsb(input int unsigned rnw);
      return 0 * rnw;
   endfunction

endpackage

// File: rtl/seq_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for DW cycles,
// done_o marks the cycle whose closing edge completes the product.
module seq_mul_iter #(
   parameter int DW  = 8,
   parameter int SAT = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic          done_o,
   output logic [DW-1:0] result_o
);

   localparam int CW = $clog2(DW + 1);

   logic [2*DW-1:0] mcand_q;
   logic [2*DW-1:0] acc_q;
   logic [2*DW-1:0] acc_d;
   logic [DW-1:0]   mplier_q;
   logic [CW-1:0]   cnt_q;
   logic            active_q;

   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
   end

   // Result includes the final partial product so it is ready on the done edge.
   assign done_o   = active_q && (cnt_q == CW'(DW - 1));
   assign result_o = ((SAT != 0) && (|acc_d[2*DW-1:DW])) ? '1 : acc_d[DW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= {{DW{1'b0}}, a_i};
         acc_q    <= '0;
         mplier_q <= b_i;
         cnt_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (done_o) active_q <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_core.sv
// Instruction sequencer: push/add/mult/send over a small register file,
// with valid/ready instruction intake and a held send toward the UART tx.
module seq_core
   import seq_core_pkg::*;
#(
   parameter  int DW   = 8,
   parameter  int NREG = 4,
   parameter  int TXW  = 8,
   parameter  int SAT  = 0,
   localparam int RNW  = $clog2(NREG),
   localparam int IW   = 2 + 3 * RNW,
   localparam int IMW  = 2 * RNW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [IW-1:0]  i_inst,
   input  logic           i_inst_valid,
   output logic           o_inst_ready,
   output logic [TXW-1:0] o_tx_data,
   output logic           o_tx_valid,
   input  logic           i_tx_busy,
   output logic           o_busy
);

   localparam int OP_LSB = op_lsb(RNW);
   localparam int RA_LSB = ra_lsb(RNW);
   localparam int RB_LSB = rb_lsb(RNW);
   localparam int RC_LSB = rc_lsb(RNW);

   state_e          state_q;
   logic [DW-1:0]   rf_q [NREG];
   logic [RNW-1:0]  rc_q;
   logic [TXW-1:0]  tx_data_q;
   logic            tx_valid_q;

   logic [1:0]      op;
   logic [RNW-1:0]  ra, rb, rc;
   logic [DW-1:0]   rd_a, rd_b, imm_dw, add_res, mul_res;
   logic [DW:0]     sum;
   logic [TXW-1:0]  tx_byte;
   logic            accept, mul_start, mul_done;
   logic            wr_en;
   logic [RNW-1:0]  wr_idx;
   logic [DW-1:0]   wr_data;

   assign op = i_inst[OP_LSB +: 2];
   assign ra = i_inst[RA_LSB +: RNW];
   assign rb = i_inst[RB_LSB +: RNW];
   assign rc = i_inst[RC_LSB +: RNW];

   assign o_inst_ready = (state_q == ST_IDLE);
   assign o_busy       = (state_q != ST_IDLE);
   assign o_tx_data    = tx_data_q;
   assign o_tx_valid   = tx_valid_q;
   assign accept       = i_inst_valid && o_inst_ready;
   assign mul_start    = accept && (op == OP_MULT);

   generate
      if (IMW >= DW) begin : g_imm_trunc
         assign imm_dw = i_inst[DW-1:0];
      end else begin : g_imm_zext
         assign imm_dw = {{(DW-IMW){1'b0}}, i_inst[IMW-1:0]};
      end
      if (DW >= TXW) begin : g_tx_trunc
         assign tx_byte = rd_a[TXW-1:0];
      end else begin : g_tx_zext
         assign tx_byte = {{(TXW-DW){1'b0}}, rd_a};
      end
   endgenerate

   // Indices with no backing register read as zero.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (ra == RNW'(i)) rd_a = rf_q[i];
         if (rb == RNW'(i)) rd_b = rf_q[i];
      end
   end

   assign sum     = {1'b0, rd_a} + {1'b0, rd_b};
   assign add_res = ((SAT != 0) && sum[DW]) ? '1 : sum[DW-1:0];

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = rc;
      wr_data = add_res;
      if (mul_done) begin
         wr_en   = 1'b1;
         wr_idx  = rc_q;
         wr_data = mul_res;
      end else if (accept && (op == OP_PUSH)) begin
         wr_en   = 1'b1;
         wr_idx  = ra;
         wr_data = imm_dw;
      end else if (accept && (op == OP_ADD)) begin
         wr_en   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < NREG; i++)
            if (wr_idx == RNW'(i)) rf_q[i] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rc_q       <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept && (op == OP_MULT)) begin
                  rc_q    <= rc;
                  state_q <= ST_MUL;
               end else if (accept && (op == OP_SEND)) begin
                  tx_data_q  <= tx_byte;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_SEND;
               end
            end
            ST_MUL: begin
               if (mul_done) state_q <= ST_IDLE;
            end
            ST_SEND: begin
               if (!i_tx_busy) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   seq_mul_iter #(
      .DW  (DW),
      .SAT (SAT)
   ) u_mul (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (mul_start),
      .a_i      (rd_a),
      .b_i      (rd_b),
      .done_o   (mul_done),
      .result_o (mul_res)
   );

endmodule

// File: tb/tb_seq_core.sv
// Scoreboarded bench for seq_core: wrap and saturating 8-bit instances in
// lockstep, plus a 16-bit / 8-register instance.
module tb_seq_core;

   localparam int PUSH = 0, ADD = 1, MULT = 2, SEND = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  inst_ab;
   logic        val_ab;
   logic [10:0] inst_c;
   logic        val_c;
   logic        tx_busy;

   logic        rdy_a, rdy_b, rdy_c;
   logic        tv_a, tv_b, tv_c;
   logic        bsy_a, bsy_b, bsy_c;
   logic [7:0]  td_a, td_b, td_c;

   always #5 clk = ~clk;

   seq_core #(.DW(8), .NREG(4), .TXW(8), .SAT(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .i_inst(inst_ab), .i_inst_valid(val_ab),
      .o_inst_ready(rdy_a), .o_tx_data(td_a), .o_tx_valid(tv_a),
      .i_tx_busy(tx_busy), .o_busy(bsy_a));

   seq_core #(.DW(8), .NREG(4), .TXW(8), .SAT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .i_inst(inst_ab), .i_inst_valid(val_ab),
      .o_inst_ready(rdy_b), .o_tx_data(td_b), .o_tx_valid(tv_b),
      .i_tx_busy(tx_busy), .o_busy(bsy_b));

   seq_core #(.DW(16), .NREG(8), .TXW(8), .SAT(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .i_inst(inst_c), .i_inst_valid(val_c),
      .o_inst_ready(rdy_c), .o_tx_data(td_c), .o_tx_valid(tv_c),
      .i_tx_busy(tx_busy), .o_busy(bsy_c));

   typedef struct {
      logic [7:0] data;
      int         len;
   } txexp_t;

   txexp_t exp_q [3][$];
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [10:0] enc(input int rnw, input int op, input int ra,
                                       input int rb, input int rc);
      return 11'((op << (3 * rnw)) | (ra << (2 * rnw)) | (rb << rnw) | rc);
   endfunction

   function automatic logic [10:0] enc_push(input int rnw, input int ra, input int imm);
      return 11'((ra << (2 * rnw)) | imm);
   endfunction

   // sel 0 drives the two 8-bit instances, sel 1 the 16-bit one.
   task automatic issue(input int sel, input logic [10:0] w, output int waited);
      bit got;
      got = 1'b0;
      waited = 0;
      if (sel == 0) begin inst_ab = w[7:0]; val_ab = 1'b1; end
      else begin inst_c = w; val_c = 1'b1; end
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if ((sel == 0) ? rdy_a : rdy_c) got = 1'b1;
         else waited++;
      end
      check("accept_timeout", 32'(got), 1);
      @(posedge clk);
      #1;
      val_ab = 1'b0;
      val_c  = 1'b0;
   endtask

   task automatic exp_tx(input int sel, input int da, input int db, input int len);
      txexp_t e;
      e.len = len;
      if (sel == 0) begin
         e.data = 8'(da); exp_q[0].push_back(e);
         e.data = 8'(db); exp_q[1].push_back(e);
      end else begin
         e.data = 8'(da); exp_q[2].push_back(e);
      end
   endtask

   // Transfer monitor: data, valid-run length and data stability per byte.
   logic       tv [3];
   logic [7:0] td [3];
   assign tv[0] = tv_a; assign tv[1] = tv_b; assign tv[2] = tv_c;
   assign td[0] = td_a; assign td[1] = td_b; assign td[2] = td_c;

   initial begin
      int         run_len [3];
      logic [7:0] first_d [3];
      bit         stable  [3];
      txexp_t     e;
      for (int i = 0; i < 3; i++) begin run_len[i] = 0; stable[i] = 1'b1; first_d[i] = '0; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (!rst_n || !tv[i]) begin
               run_len[i] = 0;
            end else begin
               if (run_len[i] == 0) begin first_d[i] = td[i]; stable[i] = 1'b1; end
               else if (td[i] !== first_d[i]) stable[i] = 1'b0;
               run_len[i]++;
               if (!tx_busy) begin
                  if (exp_q[i].size() == 0) begin
                     check($sformatf("unexpected_tx[%0d]", i), 32'(exp_q[i].size()), 1);
                  end else begin
                     e = exp_q[i].pop_front();
                     check($sformatf("tx_data[%0d]", i), 32'(td[i]), 32'(e.data));
                     check($sformatf("tx_valid_len[%0d]", i), 32'(run_len[i]), 32'(e.len));
                     check($sformatf("tx_stable[%0d]", i), 32'(stable[i]), 1);
                  end
                  run_len[i] = 0;
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] P(input int ra, input int imm);
      return enc_push(2, ra, imm);
   endfunction

   function automatic logic [10:0] I(input int op, input int ra, input int rb, input int rc);
      return enc(2, op, ra, rb, rc);
   endfunction

   initial begin
      int w;
      rst_n = 1'b0; val_ab = 1'b0; val_c = 1'b0;
      inst_ab = '0; inst_c = '0; tx_busy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready_a", 32'(rdy_a), 1);
      check("rst_busy_a", 32'(bsy_a), 0);
      check("rst_txv_a", 32'(tv_a), 0);
      check("rst_txd_a", 32'(td_a), 0);
      check("rst_ready_c", 32'(rdy_c), 1);
      check("rst_busy_c", 32'(bsy_c), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic back-to-back path with read-after-write
      issue(0, P(0, 5), w);          check("t1_push0_wait", 32'(w), 0);
      issue(0, P(1, 3), w);          check("t1_push1_wait", 32'(w), 0);
      issue(0, I(ADD, 0, 1, 2), w);  check("t1_add_wait", 32'(w), 0);
      exp_tx(0, 8, 8, 1);
      issue(0, I(SEND, 2, 0, 0), w); check("t1_send_wait", 32'(w), 0);

      // Multiply: 15*15, then 225*15 wraps to 47 or clamps to 255
      issue(0, P(0, 15), w);
      issue(0, P(1, 15), w);
      issue(0, I(MULT, 0, 1, 2), w);
      exp_tx(0, 225, 225, 1);
      issue(0, I(SEND, 2, 0, 0), w); check("t2_mul_ready_low", 32'(w), 8);
      issue(0, I(MULT, 2, 1, 3), w);
      exp_tx(0, 47, 255, 1);
      issue(0, I(SEND, 3, 0, 0), w); check("t2_mul2_ready_low", 32'(w), 8);

      // Add overflow 225+225 and same-register source/destination
      issue(0, P(3, 1), w);
      issue(0, I(MULT, 2, 3, 1), w);
      issue(0, I(MULT, 2, 3, 0), w);
      issue(0, I(ADD, 0, 1, 2), w);  check("t3_add_after_mul_wait", 32'(w), 8);
      exp_tx(0, 194, 255, 1);
      issue(0, I(SEND, 2, 0, 0), w);
      issue(0, P(3, 3), w);
      issue(0, I(ADD, 3, 3, 3), w);
      exp_tx(0, 6, 6, 1);
      issue(0, I(SEND, 3, 0, 0), w);

      // Send held by i_tx_busy for 5 cycles; next instruction stalls
      issue(0, P(3, 9), w);
      exp_tx(0, 9, 9, 6);
      tx_busy = 1'b1;
      issue(0, I(SEND, 3, 0, 0), w);
      fork
         begin
            repeat (5) @(posedge clk);
            #1;
            tx_busy = 1'b0;
         end
      join_none
      issue(0, P(0, 1), w);          check("t4_stall_cycles", 32'(w), 6);
      exp_tx(0, 1, 1, 1);
      issue(0, I(SEND, 0, 0, 0), w);

      // Asynchronous reset in MUL cycle 3
      issue(0, P(0, 15), w);
      issue(0, P(1, 15), w);
      issue(0, I(MULT, 0, 1, 2), w);
      @(posedge clk);
      @(posedge clk);
      #2;
      check("t5_busy_in_mul", 32'(bsy_a), 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_ready_a", 32'(rdy_a), 1);
      check("t5_rst_busy_a", 32'(bsy_a), 0);
      check("t5_rst_txd_a", 32'(td_a), 0);
      check("t5_rst_ready_b", 32'(rdy_b), 1);
      check("t5_rst_busy_b", 32'(bsy_b), 0);
      check("t5_rst_txv_b", 32'(tv_b), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("t5_idle_after_abort", 32'(bsy_a), 0);
      exp_tx(0, 0, 0, 1);
      issue(0, I(SEND, 2, 0, 0), w);

      // DW=16, NREG=8: 63*63 = 3969 = 0x0F81
      issue(1, enc_push(3, 7, 63), w);
      issue(1, enc(3, MULT, 7, 7, 6), w);
      exp_tx(1, 8'h81, 0, 1);
      issue(1, enc(3, SEND, 6, 0, 0), w); check("t6_mul16_ready_low", 32'(w), 16);

      for (int n = 0; n < 50; n++) begin
         if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0) break;
         @(posedge clk);
      end
      @(negedge clk);
      check("scoreboard_drained", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
